// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared state and trigger-mode encodings for the trace capture core
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        POST = 2'd2,
        DUMP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TRIG_IMM    = 2'd0,
        TRIG_MATCH  = 2'd1,
        TRIG_RISE   = 2'd2,
        TRIG_CHANGE = 2'd3
    } trig_mode_e;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port capture buffer, synchronous write, registered read
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 36,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset; it holds its word until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - logic-analyser core: pre-trigger ring buffer, four trigger modes, oldest-first dump
module trace_capture
    import trace_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 64,
    parameter int CYCLE_W  = 32,
    parameter int PTR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] probe,
    input  logic                arm,
    input  logic                abort,
    input  logic [1:0]          trig_mode,
    input  logic [CHANNELS-1:0] trig_mask,
    input  logic [CHANNELS-1:0] trig_value,
    input  logic [PTR_W-1:0]    post_count,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHANNELS-1:0] out_data,
    output logic [CYCLE_W-1:0]  out_cycle,
    output logic                out_last,
    output logic                busy,
    output logic                triggered
);

    localparam int             WORD_W = CHANNELS + CYCLE_W;
    localparam logic [PTR_W:0] FULL   = (PTR_W + 1)'(DEPTH);

    state_e               state;
    state_e               state_nxt;
    logic [CYCLE_W-1:0]   cycle_cnt;
    logic [CHANNELS-1:0]  prev;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     wr_ptr_inc;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     remaining;
    logic [PTR_W:0]       fill;
    logic [PTR_W:0]       fill_inc;
    logic [PTR_W:0]       rd_left;
    logic                 trig_hit;
    logic                 store;
    logic                 enter_dump;
    logic                 rd_en;
    logic                 out_fire;
    logic [WORD_W-1:0]    rd_word;

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode_e'(trig_mode))
            TRIG_IMM:    trig_hit = 1'b1;
            TRIG_MATCH:  trig_hit = ((probe ^ trig_value) & trig_mask) == '0;
            TRIG_RISE:   trig_hit = |(probe & ~prev & trig_mask);
            TRIG_CHANGE: trig_hit = |((probe ^ prev) & trig_mask);
            default:     trig_hit = 1'b0;
        endcase
    end

    assign store      = sample_en && !abort && (state == PRE || state == POST);
    assign wr_ptr_inc = wr_ptr + PTR_W'(1);
    assign fill_inc   = (fill == FULL) ? fill : fill + (PTR_W + 1)'(1);
    assign out_fire   = out_valid && out_ready;
    // A new word is fetched whenever the output slot is empty or being emptied.
    assign rd_en      = (state == DUMP) && !abort && (rd_left != '0) && (!out_valid || out_ready);
    assign enter_dump = (state != DUMP) && (state_nxt == DUMP);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (arm) state_nxt = PRE;
                PRE:  if (sample_en && trig_hit) state_nxt = (post_count == '0) ? DUMP : POST;
                POST: if (sample_en && remaining == PTR_W'(1)) state_nxt = DUMP;
                DUMP: if (out_fire && out_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            prev      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
            fill      <= '0;
            rd_left   <= '0;
            triggered <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (sample_en) begin
                cycle_cnt <= cycle_cnt + CYCLE_W'(1);
                prev      <= probe;
            end
            if (abort) begin
                triggered <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                rd_left   <= '0;
            end else begin
                if (state == IDLE && arm) begin
                    fill      <= '0;
                    wr_ptr    <= '0;
                    triggered <= 1'b0;
                end
                if (store) begin
                    wr_ptr <= wr_ptr_inc;
                    fill   <= fill_inc;
                end
                if (state == PRE && sample_en && trig_hit) begin
                    triggered <= 1'b1;
                    remaining <= post_count;
                end
                if (state == POST && sample_en) begin
                    remaining <= remaining - PTR_W'(1);
                end
                // Oldest entry: the buffer start once the final sample has been written.
                if (enter_dump) begin
                    rd_ptr  <= wr_ptr_inc - fill_inc[PTR_W-1:0];
                    rd_left <= fill_inc;
                end
                if (rd_en) begin
                    rd_ptr    <= rd_ptr + PTR_W'(1);
                    rd_left   <= rd_left - (PTR_W + 1)'(1);
                    out_valid <= 1'b1;
                    out_last  <= (rd_left == (PTR_W + 1)'(1));
                end else if (out_fire) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (store),
        .wr_addr (wr_ptr),
        .wr_data ({cycle_cnt, probe}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    assign {out_cycle, out_data} = rd_word;

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - self-checking bench for trace_capture
module tb_trace_capture;

    localparam int CH = 4;
    localparam int DP = 8;
    localparam int CW = 32;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_en = 1'b0;
    logic [CH-1:0] probe = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    trig_mode = '0;
    logic [CH-1:0] trig_mask = '0;
    logic [CH-1:0] trig_value = '0;
    logic [PW-1:0] post_count = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [CH-1:0] out_data;
    logic [CW-1:0] out_cycle;
    logic          out_last;
    logic          busy;
    logic          triggered;

    int total = 0;
    int bad = 0;
    int clk_n = 0;

    typedef struct {
        logic [CW-1:0] cyc;
        logic [CH-1:0] data;
        logic          last;
    } word_t;

    typedef struct {
        int mode;
        int mask;
        int val;
        int post;
        int arm_at;
        int n;
        int first;
    } vec_t;

    word_t         got[$];
    word_t         exp_q[$];
    logic [CH-1:0] samp[$];
    logic          hold_v = 1'b0;
    word_t         hold_w;

    trace_capture #(
        .CHANNELS (CH),
        .DEPTH    (DP),
        .CYCLE_W  (CW),
        .PTR_W    (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .probe      (probe),
        .arm        (arm),
        .abort      (abort),
        .trig_mode  (trig_mode),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .post_count (post_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_cycle  (out_cycle),
        .out_last   (out_last),
        .busy       (busy),
        .triggered  (triggered)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Called just after a falling edge; inputs set here take effect on the next rising edge.
    task automatic tick(input logic en, input logic [CH-1:0] p, input logic a,
                        input logic ab, input logic rdy);
        if (hold_v) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_word", 64'({out_cycle, out_data, out_last}),
                64'({hold_w.cyc, hold_w.data, hold_w.last}));
        end
        sample_en  = en;
        probe      = p;
        arm        = a;
        abort      = ab;
        out_ready  = rdy;
        hold_v     = out_valid && !rdy && !ab;
        hold_w     = '{out_cycle, out_data, out_last};
        if (out_valid && rdy && !ab) got.push_back('{out_cycle, out_data, out_last});
        if (en) samp.push_back(p);
        clk_n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        hold_v = 1'b0;
        sample_en = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        samp.delete();
        rst_n = 1'b1;
    endtask

    function automatic logic gen_en(input int ek);
        if (ek == 0) return 1'b1;
        if (ek == 1) return (clk_n % 4) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Kind 0: probe equals the low bits of the upcoming stamp on sample cycles, noise otherwise.
    function automatic logic [CH-1:0] gen_probe(input int pk, input logic en);
        if (pk == 0 && en) return CH'(samp.size());
        return CH'($urandom);
    endfunction

    task automatic capture(input int mode, input int mask, input int val, input int post,
                           input int pk, input int ek, input int rpct, output int s0);
        logic          en;
        logic [CH-1:0] p;
        bit            done;
        trig_mode  = 2'(mode);
        trig_mask  = CH'(mask);
        trig_value = CH'(val);
        post_count = PW'(post);
        got.delete();
        en = gen_en(ek);
        p  = gen_probe(pk, en);
        tick(en, p, 1'b1, 1'b0, 1'b0);
        s0 = samp.size();
        done = 0;
        for (int c = 0; c < 4000 && !done; c++) begin
            en = gen_en(ek);
            p  = gen_probe(pk, en);
            tick(en, p, 1'b0, 1'b0, 1'($urandom_range(0, 99) < rpct));
            if (got.size() != 0 && got[got.size()-1].last) done = 1;
        end
        chk("dump_done", 64'(done), 64'd1);
        chk("idle_after_dump", 64'({busy, out_valid}), 64'd0);
    endtask

    // Words expected from the sample history: trigger point plus post samples, last DEPTH kept.
    task automatic build_model(input int s0, input int mode, input int mask, input int val,
                               input int post);
        int            t;
        int            first;
        bit            hit;
        logic [CH-1:0] pv;
        logic [CH-1:0] m;
        logic [CH-1:0] v;
        exp_q.delete();
        m = CH'(mask);
        v = CH'(val);
        t = -1;
        for (int i = s0; i < samp.size() && t < 0; i++) begin
            pv = (i == 0) ? '0 : samp[i-1];
            case (mode)
                0:       hit = 1;
                1:       hit = (samp[i] & m) == (v & m);
                2:       hit = |(samp[i] & ~pv & m);
                default: hit = |((samp[i] ^ pv) & m);
            endcase
            if (hit) t = i;
        end
        if (t >= 0 && t + post < samp.size()) begin
            first = (t + post - DP + 1 > s0) ? t + post - DP + 1 : s0;
            for (int i = first; i <= t + post; i++)
                exp_q.push_back('{CW'(i), samp[i], (i == t + post)});
        end
    endtask

    task automatic compare(input string nm);
        int lasts;
        lasts = 0;
        chk({nm, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < got.size(); i++) begin
            if (got[i].last) lasts++;
            if (i < exp_q.size())
                chk($sformatf("%s_word%0d", nm, i),
                    64'({got[i].cyc, got[i].data, got[i].last}),
                    64'({exp_q[i].cyc, exp_q[i].data, exp_q[i].last}));
        end
        chk({nm, "_last_once"}, 64'(lasts), 64'd1);
    endtask

    vec_t vt[7];

    initial begin
        int s0;
        int mode;
        int mask;
        int post;
        bit seen;

        vt[0] = '{0, 0,  0, 3, 20, 4, 21};
        vt[1] = '{1, 15, 9, 2, 0,  8, 4};
        vt[2] = '{2, 4,  0, 1, 0,  5, 1};
        vt[3] = '{1, 15, 2, 5, 20, 8, 32};
        vt[4] = '{0, 0,  0, 0, 3,  1, 4};
        vt[5] = '{0, 0,  0, 7, 10, 8, 11};
        vt[6] = '{3, 15, 0, 0, 5,  1, 6};

        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({out_valid, out_last, busy, triggered, out_data, out_cycle}), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            do_reset();
            for (int j = 0; j < vt[k].arm_at; j++) tick(1'b1, CH'(samp.size()), 1'b0, 1'b0, 1'b1);
            capture(vt[k].mode, vt[k].mask, vt[k].val, vt[k].post, 0, 0, 100, s0);
            chk($sformatf("vec%0d_count", k), 64'(got.size()), 64'(vt[k].n));
            for (int i = 0; i < got.size() && i < vt[k].n; i++)
                chk($sformatf("vec%0d_word%0d", k, i),
                    64'({got[i].cyc, got[i].data, got[i].last}),
                    64'({CW'(vt[k].first + i), CH'(vt[k].first + i), (i == vt[k].n - 1)}));
            chk($sformatf("vec%0d_triggered", k), 64'(triggered), 64'd1);
        end

        // Mask of zero in change mode must never fire.
        do_reset();
        trig_mode = 2'd3; trig_mask = '0; post_count = '0;
        tick(1'b1, CH'($urandom), 1'b1, 1'b0, 1'b1);
        seen = 0;
        for (int j = 0; j < 30; j++) begin
            tick(1'b1, CH'($urandom), 1'b0, 1'b0, 1'b1);
            if (out_valid) seen = 1;
        end
        chk("mask0_no_valid", 64'(seen), 64'd0);
        chk("mask0_state", 64'({busy, triggered}), 64'b10);
        tick(1'b1, CH'($urandom), 1'b0, 1'b1, 1'b0);
        chk("mask0_abort", 64'({busy, out_valid}), 64'd0);

        // Abort during POST, then a normal re-arm.
        trig_mode = 2'd0; post_count = 3'd7;
        tick(1'b1, CH'($urandom), 1'b1, 1'b0, 1'b0);
        repeat (3) tick(1'b1, CH'($urandom), 1'b0, 1'b0, 1'b1);
        chk("post_state", 64'({busy, triggered}), 64'b11);
        tick(1'b1, CH'($urandom), 1'b0, 1'b1, 1'b0);
        chk("post_abort", 64'({busy, triggered, out_valid}), 64'd0);
        seen = 0;
        for (int j = 0; j < 15; j++) begin
            tick(1'b1, CH'($urandom), 1'b0, 1'b0, 1'b1);
            if (out_valid) seen = 1;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        tick(1'b1, CH'($urandom), 1'b1, 1'b1, 1'b0);
        chk("arm_abort_same", 64'(busy), 64'd0);
        capture(2, 6, 0, 4, 1, 2, 50, s0);
        build_model(s0, 2, 6, 0, 4);
        compare("rearm");

        // Reset while a word is presented.
        capture(0, 0, 0, 3, 1, 0, 100, s0);
        trig_mode = 2'd0; post_count = 3'd3;
        tick(1'b1, CH'($urandom), 1'b1, 1'b0, 1'b0);
        seen = 0;
        for (int j = 0; j < 20 && !seen; j++) begin
            tick(1'b1, CH'($urandom), 1'b0, 1'b0, 1'b0);
            if (out_valid) seen = 1;
        end
        chk("dump_reached", 64'(seen), 64'd1);
        #2 rst_n = 1'b0;
        hold_v = 1'b0;
        #1 chk("async_reset", 64'({out_valid, busy, triggered, out_cycle}), 64'd0);
        @(negedge clk);
        samp.delete();
        rst_n = 1'b1;
        capture(0, 0, 0, 0, 0, 0, 100, s0);
        chk("restart_stamp", 64'(got.size() != 0 ? got[0].cyc : 32'hFFFF_FFFF), 64'd1);

        // Randomized captures against the history model.
        do_reset();
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(0, 4)) tick(1'($urandom_range(0, 1)), CH'($urandom), 1'b0, 1'b0,
                                              1'($urandom_range(0, 1)));
            mode = $urandom_range(0, 3);
            mask = $urandom_range(0, 15);
            if (mode >= 2) mask = mask | (1 << $urandom_range(0, 3));
            post = $urandom_range(0, 7);
            if (mode == 1) mask = mask & 3;
            capture(mode, mask, $urandom_range(0, 15), post, 1, $urandom_range(0, 2),
                    (k % 3 == 0) ? 100 : 50, s0);
            build_model(s0, mode, mask, int'(trig_value), post);
            compare($sformatf("rand%0d", k));
            chk($sformatf("rand%0d_triggered", k), 64'(triggered), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Synthesizable, parametrised logic-analyser core. Samples a CHANNELS-wide probe vector on qualified clock edges into a DEPTH-entry ring buffer with pre-trigger history. Supports four trigger modes.
- After trigger plus post_count samples, streams captured words oldest-first over a valid/ready port. Each word carries its cycle stamp.
- Sits beside the SoC inside the wrapper and gives on-chip TRACE-style visibility of flash/GPIO pins.

Parameters:
- CHANNELS, 4, probe width (1..64)
- DEPTH, 64, buffer entries; power of two, >=4
- CYCLE_W, 32, cycle-stamp width
- PTR_W, log2(DEPTH), derived pointer width

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- sample_en  in  1  sample qualifier; 1 = this clk is a sample point
- probe  in  CHANNELS  signals under observation
- arm  in  1  pulse: start capture (honoured only in IDLE)
- abort  in  1  pulse: return to IDLE from any state
- trig_mode  in  2  0 immediate, 1 match, 2 rising-edge, 3 any-change
- trig_mask  in  CHANNELS  channels participating in trigger
- trig_value  in  CHANNELS  match pattern (mode 1)
- post_count  in  PTR_W  samples stored after trigger sample; latched at trigger
- out_valid  out  1  readout word valid
- out_ready  in  1  consumer accepts
- out_data  out  CHANNELS  stored probe value
- out_cycle  out  CYCLE_W  stored cycle stamp
- out_last  out  1  final word of dump
- busy  out  1  state != IDLE
- triggered  out  1  trigger seen in current capture; cleared on arm/abort

Behaviour:
- Reset: state IDLE. All outputs 0. Cycle counter, prev-sample register, pointers and fill count all 0.
- Cycle counter: +1 on every sample_en in all states, wraps mod 2^CYCLE_W. A sample's stamp is the counter value before increment, so the first sample after reset is 0.
- prev register: loads probe on every sample_en in all states.
- Trigger is evaluated only on sample_en cycles in PRE:
  - mode 0: true
  - mode 1: (probe & mask) == (value & mask)
  - mode 2: |(probe & ~prev & mask)
  - mode 3: |((probe ^ prev) & mask)
  - mask = 0 in modes 2/3 never triggers.
- State IDLE: on arm, clear fill, wr_ptr, triggered, then go to PRE. A sample in the arm cycle is not stored.
- State PRE: each sample is written at wr_ptr, wr_ptr++ (wraps), fill saturates at DEPTH. If the trigger fires, that sample is stored, triggered=1, remaining=post_count latched. Go to POST, or to DUMP if post_count = 0.
- State POST: each sample is stored, remaining--. After storing the sample that reaches remaining = 0, go to DUMP.
- State DUMP:
  - rd_ptr = wr_ptr - fill (mod DEPTH).
  - First word is registered; out_valid rises 1-2 clk after entry.
  - Each out_valid && out_ready advances to the next word.
  - out_data/out_cycle/out_last stay stable while out_valid && !out_ready.
  - out_last=1 on word number fill.
  - After the last handshake, the next cycle has out_valid=0, state IDLE, busy=0.
  - Samples arriving in DUMP are not stored.
- Word count: min(pre-trigger samples stored + 1 + post_count, DEPTH). Overwritten samples are dropped oldest-first.
- abort: any state goes to IDLE next clk. out_valid drops next clk. Abort and arm in the same cycle: abort wins. arm outside IDLE is ignored.
- rst_n low at any time, including mid-DUMP: asynchronous return to reset values.
- Stored word: {cycle stamp, probe}, CHANNELS+CYCLE_W bits.

Decomposition:
- Package trace_pkg: state enum (IDLE, PRE, POST, DUMP), trig_mode encodings (TRIG_IMM=0, TRIG_MATCH=1, TRIG_RISE=2, TRIG_CHANGE=3).
- Sub-module trace_ram: simple dual-port, DEPTH x (CHANNELS+CYCLE_W), synchronous write, 1-cycle registered read, no reset on array.

Test Plan:
- Immediate: CHANNELS=4, DEPTH=8, sample_en=1, probe = stamp[3:0], post_count=3, arm with counter at 20 -> 4 words, stamps 21..24, data 5..8, out_last on 24.
- Match: mode 1, mask=F, value=9, post_count=2, armed at stamp 0 -> 8 words, data 4,5,6,7,8,9,A,B, triggered=1, only the first 9 triggers.
- Rising edge, short history: mode 2, mask=4, probe bit2 rises on the 4th sample after arm, post_count=1 -> exactly 5 words; word 4 has bit2=1, word 3 has bit2=0.
- Qualified sampling: sample_en every 4th clk, mode 0, post_count=2 -> stamps consecutive (n, n+1, n+2); probe glitches between sample_en cycles are never captured.
- Backpressure: out_ready random 50% in DUMP -> every word delivered once, in order; outputs stable during stalls; out_last asserted once.
- Abort/reset: abort in POST -> out_valid never rises, busy=0 next clk, re-arm captures normally. rst_n low mid-DUMP -> out_valid=0 immediately and cycle counter restarts at 0.
